// File: rtl/game_net_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_net_pkg
// Description : Shared types and helpers for the opponent-state link.
//               Used by the transmit framer and the receive-side deframer.
// Revision    : 1.0 - initial release
// ============================================================================
package game_net_pkg;

  // First byte of every packet unless a block overrides it
  localparam logic [7:0] HEADER_DEFAULT  = 8'hA5;
  // Fixed packet length: header, seq, five payload bytes, check byte
  localparam int         PKT_BYTES       = 8;
  // Idle cycles inserted after the last beat of a packet
  localparam int         MIN_GAP_DEFAULT = 4;

  // Snapshot of the local player; field order is the on-wire bit order
  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [8:0]  dir;
    logic [2:0]  stat;
    logic        rst_req;
  } player_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_t;

  // One byte of CRC-8, poly 0x07, MSB first, no reflection
  function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                           input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/player_state_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : player_state_tx_if
// Description : Byte-wide AXI-Stream link from the framer to the network TX.
// Revision    : 1.0 - initial release
// ============================================================================
interface player_state_tx_if;

  logic       axiov;
  logic [7:0] axiod;
  logic       axiol;
  logic       axiir;

  modport master (output axiov, output axiod, output axiol, input axiir);
  modport slave  (input axiov, input axiod, input axiol, output axiir);

endinterface
`default_nettype wire

// File: rtl/net_checksum.sv
`default_nettype none
// ============================================================================
// Module      : net_checksum
// Description : Running packet check accumulator. XOR of all enabled bytes
//               by default; CRC-8 (poly 0x07, init 0) when PLAYER_TX_CRC8_EN
//               is defined. sum already includes the byte presented this
//               cycle when en is high, so the framer can load the final
//               check byte on the same edge the last payload byte leaves.
// Revision    : 1.0 - initial release
// ============================================================================
module net_checksum
  import game_net_pkg::*;
(
  input  wire        clk,
  input  wire        rst,
  input  wire        clr,
  input  wire        en,
  input  wire  [7:0] data,
  output logic [7:0] sum
);

  logic [7:0] acc_q;
  logic [7:0] acc_d;

  // Next accumulator value: clear wins over accumulate
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = 8'h00;
    end else if (en) begin
`ifdef PLAYER_TX_CRC8_EN
      acc_d = crc8_step(acc_q, data);
`else
      acc_d = acc_q ^ data;
`endif
    end
  end

  assign sum = acc_d;

  // Accumulator register
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= 8'h00;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/player_state_tx.sv
`default_nettype none
// ============================================================================
// Module      : player_state_tx
// Description : Opponent-state link transmitter. Snapshots the local player
//               state on a send trigger and streams an 8-byte packet
//               {HEADER, seq, payload[4:0], check} over byte AXI-Stream,
//               followed by MIN_GAP idle cycles. One trigger may be queued
//               while busy; further ones are counted as drops.
//               Build option: PLAYER_TX_CRC8_EN selects a CRC-8 check byte
//               instead of the XOR checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module player_state_tx
  import game_net_pkg::*;
#(
  parameter logic [7:0] HEADER  = HEADER_DEFAULT,
  parameter int         MIN_GAP = MIN_GAP_DEFAULT
) (
  input  wire                 clk,
  input  wire                 rst,
  input  wire                 send_trig,
  input  wire  [10:0]         player_x,
  input  wire  [10:0]         player_y,
  input  wire  [8:0]          player_dir,
  input  wire  [2:0]          game_stat,
  input  wire                 rst_req,
  output logic                busy,
  output logic [7:0]          drop_cnt,
  player_state_tx_if.master   axis
);

  localparam int              GAP_W    = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MIN_GAP - 1);

  tx_state_t       state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]      seq_q, seq_d;
  logic            pending_q, pending_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;
  player_state_t   snap_q, snap_d;
  logic            axiov_q, axiov_d;
  logic [7:0]      axiod_q, axiod_d;
  logic            axiol_q, axiol_d;
  logic            busy_q, busy_d;

  logic            beat_fire;
  logic            last_beat;
  logic            gap_done;
  logic            start_pkt;
  logic            trig_busy;
  logic            chk_en;
  logic [7:0]      chk_sum;
  logic [39:0]     payload;
  logic [7:0]      next_byte;

  // Event decode: beats, gap expiry, packet starts and triggers that arrive busy
  always_comb begin
    beat_fire = axiov_q && axis.axiir;
    last_beat = beat_fire && (idx_q == 3'd7);
    gap_done  = (state_q == GAP) && (gap_cnt_q == GAP_LAST);
    // A trigger coinciding with the gap expiry starts a packet directly
    start_pkt = ((state_q == IDLE) && send_trig)
              || (gap_done && (pending_q || send_trig));
    // Promotion consumes the pending slot, so a trigger on that edge is a drop
    trig_busy = send_trig
              && ((state_q == SEND) || ((state_q == GAP) && (!gap_done || pending_q)));
    // Only seq and payload bytes feed the check byte
    chk_en    = beat_fire && (idx_q != 3'd0) && (idx_q != 3'd7);
  end

  net_checksum u_checksum (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_pkt),
    .en   (chk_en),
    .data (axiod_q),
    .sum  (chk_sum)
  );

  // Byte that follows the one currently on the bus
  always_comb begin
    payload = {snap_q, 5'b00000};
    case (idx_q)
      3'd0:    next_byte = seq_q;
      3'd1:    next_byte = payload[39:32];
      3'd2:    next_byte = payload[31:24];
      3'd3:    next_byte = payload[23:16];
      3'd4:    next_byte = payload[15:8];
      3'd5:    next_byte = payload[7:0];
      default: next_byte = chk_sum;
    endcase
  end

  // Next-state and next-output logic; outputs only move on a transfer or start
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    gap_cnt_d  = gap_cnt_q;
    seq_d      = seq_q;
    pending_d  = pending_q;
    drop_cnt_d = drop_cnt_q;
    snap_d     = snap_q;
    axiov_d    = axiov_q;
    axiod_d    = axiod_q;
    axiol_d    = axiol_q;

    if (start_pkt) begin
      state_d   = SEND;
      idx_d     = 3'd0;
      gap_cnt_d = '0;
      snap_d    = {player_x, player_y, player_dir, game_stat, rst_req};
      axiov_d   = 1'b1;
      axiod_d   = HEADER;
      axiol_d   = 1'b0;
    end else begin
      case (state_q)
        SEND: begin
          if (beat_fire) begin
            if (idx_q == 3'd7) begin
              state_d   = GAP;
              gap_cnt_d = '0;
              axiov_d   = 1'b0;
              axiod_d   = 8'h00;
              axiol_d   = 1'b0;
            end else begin
              idx_d   = idx_q + 3'd1;
              axiod_d = next_byte;
              axiol_d = (idx_q == 3'd6);
            end
          end
        end
        GAP: begin
          if (gap_done) begin
            state_d = IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (last_beat) begin
      seq_d = seq_q + 8'd1;
    end

    if (gap_done && pending_q) begin
      pending_d = 1'b0;
    end
    if (trig_busy) begin
      if (!pending_q) begin
        pending_d = 1'b1;
      end else if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  // Framer state machine register, including the registered stream outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      gap_cnt_q  <= '0;
      seq_q      <= 8'h00;
      pending_q  <= 1'b0;
      drop_cnt_q <= 8'h00;
      snap_q     <= '0;
      axiov_q    <= 1'b0;
      axiod_q    <= 8'h00;
      axiol_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      gap_cnt_q  <= gap_cnt_d;
      seq_q      <= seq_d;
      pending_q  <= pending_d;
      drop_cnt_q <= drop_cnt_d;
      snap_q     <= snap_d;
      axiov_q    <= axiov_d;
      axiod_q    <= axiod_d;
      axiol_q    <= axiol_d;
      busy_q     <= busy_d;
    end
  end

  assign axis.axiov = axiov_q;
  assign axis.axiod = axiod_q;
  assign axis.axiol = axiol_q;
  assign busy       = busy_q;
  assign drop_cnt   = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_player_state_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_player_state_tx
// Description : Self-checking bench for player_state_tx: table of known
//               packets, directed multi-cycle sequences and a randomized run
//               against a packet-level reference model.
//               Honours PLAYER_TX_CRC8_EN for the expected check byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_player_state_tx;

  localparam logic [7:0] HDR = 8'hA5;
  localparam int         GAP = 4;

  typedef logic [7:0][7:0] pkt_t;   // pkt[i] is byte i

  typedef struct {
    logic [10:0] x;
    logic [10:0] y;
    logic [8:0]  dir;
    logic [2:0]  st;
    logic        rr;
    logic [47:0] body;   // bytes 1..6, byte 1 in the top bits
    logic [7:0]  xsum;   // XOR check byte
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        send_trig;
  logic [10:0] px, py;
  logic [8:0]  pdir;
  logic [2:0]  pstat;
  logic        prr;
  logic        busy;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  player_state_tx_if axis_if ();

  player_state_tx #(.HEADER(HDR), .MIN_GAP(GAP)) dut (
    .clk        (clk),
    .rst        (rst),
    .send_trig  (send_trig),
    .player_x   (px),
    .player_y   (py),
    .player_dir (pdir),
    .game_stat  (pstat),
    .rst_req    (prr),
    .busy       (busy),
    .drop_cnt   (drop_cnt),
    .axis       (axis_if)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model helpers ----------------
  function automatic logic [7:0] ref_check(input logic [47:0] body);
`ifdef PLAYER_TX_CRC8_EN
    logic [55:0] r;
    r = {body, 8'h00};
    for (int i = 55; i >= 8; i--) begin
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    end
    return r[7:0];
`else
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < 6; i++) s = s ^ body[8*i +: 8];
    return s;
`endif
  endfunction

  function automatic pkt_t ref_packet(input logic [7:0] seq, input logic [10:0] x,
                                      input logic [10:0] y, input logic [8:0] dir,
                                      input logic [2:0] st, input logic rr);
    logic [47:0] body;
    pkt_t p;
    body = {seq, x, y, dir, st, rr, 5'b00000};
    p[0] = HDR;
    for (int i = 1; i <= 6; i++) p[i] = body[8*(6-i) +: 8];
    p[7] = ref_check(body);
    return p;
  endfunction

  // ---------------- bench utilities ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_in(input logic [10:0] x, input logic [10:0] y, input logic [8:0] d,
                        input logic [2:0] s, input logic r);
    px = x; py = y; pdir = d; pstat = s; prr = r;
  endtask

  // Pulse send_trig for one cycle and check the header appears next cycle
  task automatic trig_pkt(input string name);
    send_trig = 1'b1;
    cyc();
    send_trig = 1'b0;
    chk({name, "_latency"}, axis_if.axiov, 1'b1);
  endtask

  // Collect eight accepted beats; optionally stall stall_len cycles at stall_at
  task automatic capture(input int stall_at, input int stall_len, output pkt_t got,
                         output int n, output int last_bad, output int hold_bad,
                         output logic [7:0] held);
    int stalls;
    stalls = 0; n = 0; last_bad = 0; hold_bad = 0; got = '0; held = 8'h00;
    for (int c = 0; c < 64 && n < 8; c++) begin
      if (n == stall_at && stalls < stall_len) begin
        axis_if.axiir = 1'b0;
        if (stalls == 0) held = axis_if.axiod;
        else if (axis_if.axiod !== held || axis_if.axiov !== 1'b1) hold_bad++;
        stalls++;
      end else begin
        axis_if.axiir = 1'b1;
      end
      if (axis_if.axiov && axis_if.axiir) begin
        got[n] = axis_if.axiod;
        if (axis_if.axiol !== (n == 7)) last_bad++;
        n++;
      end
      cyc();
    end
    if (stall_len > 0 && got[stall_at] !== held) hold_bad++;
    axis_if.axiir = 1'b1;
  endtask

  task automatic cmp_pkt(input string name, input pkt_t got, input pkt_t exp);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_b%0d", name, i), got[i], exp[i]);
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 30 && busy; c++) cyc();
    chk({name, "_idle"}, busy, 1'b0);
  endtask

  // ---------------- randomized-run model state ----------------
  int         m_phase;   // 0 idle, 1 sending, 2 gap
  int         m_beat;
  int         m_gap;
  logic [7:0] m_seq;
  bit         m_pend;
  int         m_drop;
  pkt_t       m_pkt;

  task automatic m_busy_trig();
    if (send_trig) begin
      if (m_pend) begin
        if (m_drop < 255) m_drop++;
      end else m_pend = 1'b1;
    end
  endtask

  task automatic m_start();
    m_phase = 1; m_beat = 0;
    m_pkt = ref_packet(m_seq, px, py, pdir, pstat, prr);
  endtask

  // Advance the model across one clock edge using the inputs now driven
  task automatic m_step();
    case (m_phase)
      0: if (send_trig) m_start();
      1: begin
        m_busy_trig();
        if (axis_if.axiir) begin
          if (m_beat == 7) begin
            m_seq++; m_phase = 2; m_gap = GAP;
          end else m_beat++;
        end
      end
      default: begin
        if (m_gap > 1) begin
          m_busy_trig();
          m_gap--;
        end else if (m_pend) begin
          m_pend = 1'b0;
          if (send_trig) begin
            if (m_drop < 255) m_drop++;
          end
          m_start();
        end else if (send_trig) m_start();
        else m_phase = 0;
      end
    endcase
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[3];

  initial begin
    pkt_t got, exp;
    int n, lb, hb, idle, bad, wrap_seen, stray;
    logic [7:0] held, exp_seq, prev_b1, exp7;
    bit t2, t3;

    vecs[0] = '{11'd100,   11'd100,   9'd90,  3'd0, 1'b0, 48'h00_0C_81_90_B4_00, 8'hA9};
    vecs[1] = '{11'h7FF,   11'd0,     9'd359, 3'd7, 1'b1, 48'h01_FF_E0_02_CF_E0, 8'h33};
    vecs[2] = '{11'h2AA,   11'h555,   9'd170, 3'd5, 1'b0, 48'h02_55_55_55_55_40, 8'h42};

    rst = 1'b1; send_trig = 1'b0; axis_if.axiir = 1'b1;
    set_in(11'd0, 11'd0, 9'd0, 3'd0, 1'b0);
    repeat (3) cyc();
    chk("rst_axiov", axis_if.axiov, 1'b0);
    chk("rst_axiod", axis_if.axiod, 8'h00);
    chk("rst_axiol", axis_if.axiol, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_drop", drop_cnt, 8'h00);
    rst = 1'b0;
    cyc();

    // Table of known packets, back-to-back with a free-running sink
    for (int v = 0; v < 3; v++) begin
      set_in(vecs[v].x, vecs[v].y, vecs[v].dir, vecs[v].st, vecs[v].rr);
      trig_pkt($sformatf("tbl%0d", v));
      capture(-1, 0, got, n, lb, hb, held);
      chk($sformatf("tbl%0d_len", v), n, 8);
      chk($sformatf("tbl%0d_b0", v), got[0], HDR);
      for (int i = 1; i <= 6; i++)
        chk($sformatf("tbl%0d_b%0d", v, i), got[i], vecs[v].body[8*(6-i) +: 8]);
`ifdef PLAYER_TX_CRC8_EN
      exp7 = ref_check(vecs[v].body);
`else
      exp7 = vecs[v].xsum;
`endif
      chk($sformatf("tbl%0d_b7", v), got[7], exp7);
      chk($sformatf("tbl%0d_axiol", v), lb, 0);
      for (int g = 0; g < GAP; g++) begin
        chk($sformatf("tbl%0d_gap%0d_axiov", v, g), axis_if.axiov, 1'b0);
        chk($sformatf("tbl%0d_gap%0d_busy", v, g), busy, 1'b1);
        cyc();
      end
      chk($sformatf("tbl%0d_back_idle", v), busy, 1'b0);
    end
    exp_seq = 8'd3;

    // Backpressure: three stall cycles while byte3 is offered
    set_in(11'd100, 11'd100, 9'd90, 3'd0, 1'b0);
    exp = ref_packet(exp_seq, 11'd100, 11'd100, 9'd90, 3'd0, 1'b0);
    trig_pkt("bp");
    capture(3, 3, got, n, lb, hb, held);
    chk("bp_len", n, 8);
    cmp_pkt("bp", got, exp);
    chk("bp_hold_stable", hb, 0);
    chk("bp_hold_value", held, 8'h81);
    chk("bp_axiol", lb, 0);
    wait_idle("bp");
    exp_seq++;

    // Snapshot: input change after the trigger must not reach the packet
    set_in(11'd100, 11'd100, 9'd90, 3'd0, 1'b0);
    exp = ref_packet(exp_seq, 11'd100, 11'd100, 9'd90, 3'd0, 1'b0);
    trig_pkt("snap");
    px = 11'd500;
    capture(-1, 0, got, n, lb, hb, held);
    chk("snap_len", n, 8);
    cmp_pkt("snap", got, exp);
    wait_idle("snap");
    exp_seq++;

    // Overlap: queued trigger during SEND, a third one is dropped
    set_in(11'd100, 11'd100, 9'd90, 3'd0, 1'b0);
    exp = ref_packet(exp_seq, 11'd100, 11'd100, 9'd90, 3'd0, 1'b0);
    trig_pkt("ovl");
    n = 0; got = '0; t2 = 1'b0; t3 = 1'b0;
    for (int c = 0; c < 40 && n < 8; c++) begin
      send_trig = 1'b0;
      if (n == 2 && !t2) begin
        send_trig = 1'b1; t2 = 1'b1;
        set_in(11'h7FF, 11'd0, 9'd359, 3'd7, 1'b1);
      end else if (n == 4 && !t3) begin
        send_trig = 1'b1; t3 = 1'b1;
      end
      if (axis_if.axiov && axis_if.axiir) begin
        got[n] = axis_if.axiod;
        n++;
      end
      cyc();
    end
    send_trig = 1'b0;
    chk("ovl1_len", n, 8);
    cmp_pkt("ovl1", got, exp);
    idle = 0;
    while (!axis_if.axiov && idle < 20) begin
      idle++;
      cyc();
    end
    chk("ovl_gap_cycles", idle, GAP);
    chk("ovl_drop", drop_cnt, 8'd1);
    exp_seq++;
    exp = ref_packet(exp_seq, 11'h7FF, 11'd0, 9'd359, 3'd7, 1'b1);
    capture(-1, 0, got, n, lb, hb, held);
    chk("ovl2_len", n, 8);
    cmp_pkt("ovl2", got, exp);
    wait_idle("ovl2");
    exp_seq++;

    // Sequence wrap over 256 packets
    set_in(11'd100, 11'd100, 9'd90, 3'd0, 1'b0);
    bad = 0; wrap_seen = 0; prev_b1 = 8'h00;
    for (int p = 0; p < 256; p++) begin
      send_trig = 1'b1;
      cyc();
      send_trig = 1'b0;
      capture(-1, 0, got, n, lb, hb, held);
      if (n != 8 || got[1] !== exp_seq) bad++;
      if (p > 0 && prev_b1 == 8'hFF && got[1] == 8'h00) wrap_seen = 1;
      prev_b1 = got[1];
      exp_seq++;
      for (int c = 0; c < 30 && busy; c++) cyc();
    end
    chk("wrap_seq_errors", bad, 0);
    chk("wrap_ff_to_00", wrap_seen, 1);

    // Reset while byte4 is on the bus
    send_trig = 1'b1;
    cyc();
    send_trig = 1'b0;
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      if (axis_if.axiov && axis_if.axiir) n++;
      cyc();
    end
    rst = 1'b1;
    cyc();
    chk("mrst_axiov", axis_if.axiov, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_drop", drop_cnt, 8'h00);
    rst = 1'b0;
    stray = 0;
    for (int c = 0; c < 10; c++) begin
      if (axis_if.axiov) stray++;
      cyc();
    end
    chk("mrst_no_beats", stray, 0);
    exp = ref_packet(8'h00, 11'd100, 11'd100, 9'd90, 3'd0, 1'b0);
    trig_pkt("mrst_next");
    capture(-1, 0, got, n, lb, hb, held);
    chk("mrst_next_len", n, 8);
    cmp_pkt("mrst_next", got, exp);
    wait_idle("mrst_next");

    // Randomized run against the packet-level model
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    m_phase = 0; m_beat = 0; m_gap = 0; m_seq = 8'h00; m_pend = 1'b0; m_drop = 0; m_pkt = '0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_axiov", axis_if.axiov, (m_phase == 1));
      chk("rnd_busy", busy, (m_phase != 0));
      chk("rnd_drop", drop_cnt, m_drop);
      if (m_phase == 1) begin
        chk("rnd_axiod", axis_if.axiod, m_pkt[m_beat]);
        chk("rnd_axiol", axis_if.axiol, (m_beat == 7));
      end
      px    = 11'($urandom);
      py    = 11'($urandom);
      pdir  = 9'($urandom_range(359, 0));
      pstat = 3'($urandom);
      prr   = 1'($urandom);
      send_trig     = ($urandom_range(7, 0) < ((c < 1500) ? 1 : 7));
      axis_if.axiir = ($urandom_range(9, 0) < 7);
      m_step();
      cyc();
    end
    send_trig = 1'b0;
    chk("rnd_drop_saturated", drop_cnt, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/player_state_tx.md
Name: player_state_tx

Overview:
Transmit end of the opponent-state link; the game module's r_opp_* inputs come from the receive end.
- On each send trigger, snapshots local player state (x, y, direction, game status, reset request).
- Frames the snapshot into a fixed 8-byte packet and streams it out over AXI-Stream, one byte per beat, toward the network TX path.
- Sits between the game logic and the link transmitter.

Parameters:
HEADER, 8'hA5, first byte of every packet.
MIN_GAP, 4, idle cycles (axiov low) forced after the last beat of a packet is accepted.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
send_trig  in  1  one-cycle pulse requesting a packet (game drives it once per frame)
player_x  in  11  local x position
player_y  in  11  local y position
player_dir  in  9  heading in degrees, 0..359
game_stat  in  3  local game status
rst_req  in  1  request that the opponent reset
axiir  in  1  downstream ready
axiov  out  1  byte valid
axiod  out  8  byte data
axiol  out  1  last byte of packet
busy  out  1  packet in flight or in gap
drop_cnt  out  8  triggers dropped, saturating

Behaviour:
- Reset values: axiov=0, axiod=0, axiol=0, busy=0, drop_cnt=0, seq=0, pending=0, state=IDLE. A reset mid-packet abandons the packet; no further beats are sent.
- Payload P[39:0] = {player_x, player_y, player_dir, game_stat, rst_req, 5'b0}.
- Packet byte order:
  - byte0 = HEADER
  - byte1 = seq
  - bytes2..6 = P[39:32], P[31:24], P[23:16], P[15:8], P[7:0]
  - byte7 = checksum = XOR of bytes1..6
  - axiol is high only on byte7.
- Snapshot: all inputs are registered in the cycle send_trig is sampled high (or when a pending request is promoted). Input changes afterward do not affect the packet.
- States:
  - IDLE: on send_trig -> SEND, byte index 0. Latency: trig at cycle N -> axiov=1 with HEADER at N+1.
  - SEND: axiov=1. A beat transfers when axiov && axiir. axiod/axiol are held stable while axiir=0. On transfer of byte7: seq <= seq+1 (wraps 255->0), then -> GAP.
  - GAP: axiov=0 for exactly MIN_GAP cycles, then -> SEND if pending (pending cleared, snapshot taken at that cycle), otherwise -> IDLE.
- busy=1 in SEND and GAP.
- Triggers while busy:
  - First trigger sets pending; it is one deep.
  - A trigger while pending is already set is dropped: drop_cnt += 1, saturating at 255.
  - A trigger in the same cycle as the GAP->IDLE decision counts as pending and is sent without returning to IDLE.
- Checksum is accumulated per accepted beat, not precomputed from stale data.

Optional Feature:
PLAYER_TX_CRC8_EN
- Defined: byte7 = CRC-8 (poly 0x07, init 0x00, no reflection, no final XOR) over bytes1..6.
- Undefined: byte7 = XOR checksum as above.
- Packet length and timing are identical in both cases.

Decomposition:
- Package game_net_pkg holds:
  - HEADER_DEFAULT and PKT_BYTES=8
  - packed struct player_state_t {x, y, dir, stat, rst_req}
  - state enum {IDLE, SEND, GAP}
  - function crc8_step(crc, byte)
- The package is shared with the receive-side deframer.
- One sub-module, net_checksum: a running accumulator with clear/enable/byte in/sum out, switched XOR/CRC by the macro.

Test Plan:
- Basic packet: reset, x=100, y=100, dir=90, stat=0, rst_req=0, axiir=1, one trig -> bytes A5 00 0C 81 90 B4 00 A9 on 8 consecutive cycles starting 1 cycle after trig, axiol only on A9, then 4 idle cycles.
- Backpressure: axiir=0 for 3 cycles during byte3 -> axiod holds 0x81, no byte skipped or duplicated.
- Overlap: second trig during SEND -> second packet seq=01 starts exactly MIN_GAP cycles after the first packet's last beat. A third trig while pending -> drop_cnt=1.
- Snapshot: change player_x to 500 the cycle after trig -> packet still carries 100 (0C 81 ...).
- Sequence wrap: 256 packets -> seq field goes FF then 00.
- Reset mid-packet: rst asserted at byte4 -> axiov=0 next cycle, seq=0, drop_cnt=0. With PLAYER_TX_CRC8_EN defined, the basic packet's byte7 equals the CRC-8 of 00 0C 81 90 B4 00 from the reference model.
